konwersja_pipe: RTL
===================

KONWERSJA_PIPE -- requirements
Module: konwersja_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data word width in bits; legal values are WIDTH >= 2.
REQ-002 SHALL provide parameter CNT_W, default 8, error-counter width in bits; legal values are CNT_W >= 1.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1 bit: input word present.
REQ-006 SHALL have port o_ready, output, 1 bit: block can accept an input word this cycle.
REQ-007 SHALL have port i_mode, input, 2 bits: conversion mode, sampled with i_argA.
REQ-008 SHALL have port i_argA, input, WIDTH bits: operand.
REQ-009 SHALL have port o_valid, output, 1 bit: result present.
REQ-010 SHALL have port i_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port o_result, output, WIDTH bits: converted word.
REQ-012 SHALL have port o_error, output, 1 bit: result not representable; o_result holds the saturated value.
REQ-013 SHALL have port i_err_clr, input, 1 bit: clear the error counter.
REQ-014 SHALL have port o_err_cnt, output, CNT_W bits: saturating count of error results delivered.

Function
REQ-015 SHALL accept an input word on a rising edge where i_valid=1 and o_ready=1, and deliver it on a rising edge where o_valid=1 and i_ready=1.
REQ-016 SHALL implement a 2-stage pipeline: stage 1 registers i_argA and i_mode; stage 2 registers o_result and o_error; a word accepted at edge N is presented with o_valid=1 after edge N+1.
REQ-017 SHALL assert o_ready = !s1_valid || s1_advance, where s1_advance = !o_valid || i_ready; the throughput is 1 word per cycle while i_ready=1.
REQ-018 SHALL hold o_result and o_error stable while o_valid=1 and i_ready=0; no word is dropped or duplicated, and words are delivered in acceptance order.
REQ-019 SHALL, for mode 00 (pass), produce o_result = argA and o_error = 0.
REQ-020 SHALL, for mode 01 (two's complement to sign-magnitude), map a non-negative argA to itself; a negative argA maps to {1, magnitude}.
REQ-021 SHALL, for mode 01 with argA = 1 followed by zeros (most negative), produce o_result = all ones and o_error = 1.
REQ-022 SHALL, for mode 10 (sign-magnitude to two's complement), map a positive argA to itself; a negative argA maps to -magnitude.
REQ-023 SHALL, for mode 10 with negative zero (1 followed by zeros), produce o_result = 0 and o_error = 0.
REQ-024 SHALL, for mode 11 (two's complement to one's complement), map a non-negative argA to itself; a negative argA maps to argA - 1.
REQ-025 SHALL, for mode 11 with the most negative argA, produce o_result = 1 followed by zeros (saturated) and o_error = 1.
REQ-026 SHALL perform all arithmetic modulo 2^WIDTH with no widening of o_result.
REQ-027 SHALL increment o_err_cnt on each delivery edge where o_error = 1.
REQ-028 SHALL saturate o_err_cnt at 2^CNT_W - 1.
REQ-029 SHALL, when i_err_clr = 1, set o_err_cnt to 0 on that edge; the clear takes priority over a simultaneous increment.

Reset
REQ-030 SHALL, on an edge with i_rst = 1, clear s1_valid and o_valid, and set o_result = 0, o_error = 0, o_err_cnt = 0.
REQ-031 SHALL discard in-flight words when reset is asserted mid-stream.
REQ-032 SHALL drive o_ready = 1 in the first cycle after reset is released.
REQ-033 SHALL give i_rst priority over every other input.

Verification (WIDTH=8, CNT_W=8 unless stated)
REQ-034 SHALL verify mode 01: argA = 0xFB accepted at edge N -> o_valid after edge N+1 with o_result = 0x85, o_error = 0; argA = 0x05 -> o_result = 0x05.
REQ-035 SHALL verify mode 01: argA = 0x80 -> o_result = 0xFF, o_error = 1; after delivery o_err_cnt = 1.
REQ-036 SHALL verify mode 10: argA = 0x85 -> o_result = 0xFB; argA = 0x80 -> o_result = 0x00, o_error = 0.
REQ-037 SHALL verify mode 11: argA = 0xFB -> o_result = 0xFA; argA = 0x80 -> o_result = 0x80, o_error = 1.
REQ-038 SHALL verify backpressure: i_ready = 0 with 3 words offered -> 2 accepted, then o_ready = 0; after i_ready = 1, all 3 words are delivered in order with no gaps.
REQ-039 SHALL verify the error counter and reset: with CNT_W = 2, 5 error deliveries -> o_err_cnt = 3; i_err_clr on an error-delivery edge -> o_err_cnt = 0; i_rst with 2 words in flight -> o_valid = 0 on the next cycle and neither word is delivered.

Source files
------------

// File: rtl/konwersja_pipe.sv
// ---------------------------------------------------------------------------
// konwersja_pipe -- two-stage, valid/ready number-format converter.
//
// Stage 1 captures the operand and mode. Stage 2 holds the converted word and
// its error flag until downstream takes it. A saturating counter tracks how
// many error results have been delivered.
//
// Modes:
//   00  pass-through
//   01  two's complement  -> sign-magnitude   (most negative saturates, error)
//   10  sign-magnitude    -> two's complement (negative zero maps to 0)
//   11  two's complement  -> one's complement (most negative saturates, error)
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid / o_ready   input handshake, carries i_mode and i_argA
//   o_valid / i_ready   output handshake, carries o_result and o_error
//   i_err_clr           clears o_err_cnt (wins over a same-edge increment)
//   o_err_cnt           saturating count of delivered error results
// ---------------------------------------------------------------------------
module konwersja_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_argA,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_error,
    input  logic             i_err_clr,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    // Stage 1
    logic             r_s1_valid;
    logic [1:0]       r_s1_mode;
    logic [WIDTH-1:0] r_s1_arg;

    // Stage 2 / outputs
    logic             r_o_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_error;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_s1_advance;
    logic             w_ready;
    logic             w_deliver;
    logic [WIDTH-1:0] w_res;
    logic             w_err;
    logic [WIDTH-1:0] w_neg;      // two's complement negation of the operand
    logic [WIDTH-1:0] w_sm_neg;   // -magnitude of a sign-magnitude operand
    logic             w_is_min;

    // Stage 2 can take a new word when it is empty or being drained.
    assign w_s1_advance = !r_o_valid || i_ready;
    assign w_ready      = !r_s1_valid || w_s1_advance;
    assign w_deliver    = r_o_valid && i_ready;

    assign w_neg    = -r_s1_arg;
    assign w_sm_neg = -{1'b0, r_s1_arg[WIDTH-2:0]};
    assign w_is_min = (r_s1_arg == MOST_NEG);

    always_comb begin
        w_res = r_s1_arg;
        w_err = 1'b0;
        case (r_s1_mode)
            2'b01: begin
                if (r_s1_arg[WIDTH-1]) begin
                    if (w_is_min) begin
                        // Magnitude 2^(WIDTH-1) does not fit; clamp to the
                        // most negative sign-magnitude value.
                        w_res = '1;
                        w_err = 1'b1;
                    end else begin
                        w_res = {1'b1, w_neg[WIDTH-2:0]};
                    end
                end
            end
            2'b10: begin
                // Negative zero falls out naturally as -0 = 0.
                if (r_s1_arg[WIDTH-1]) w_res = w_sm_neg;
            end
            2'b11: begin
                if (r_s1_arg[WIDTH-1]) begin
                    if (w_is_min) begin
                        // argA-1 would wrap positive; hold at the most
                        // negative code instead.
                        w_res = MOST_NEG;
                        w_err = 1'b1;
                    end else begin
                        w_res = r_s1_arg - ONE_W;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 2'b00;
            r_s1_arg   <= '0;
        end else if (w_ready) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_mode <= i_mode;
                r_s1_arg  <= i_argA;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_o_valid <= 1'b0;
            r_result  <= '0;
            r_error   <= 1'b0;
        end else if (w_s1_advance) begin
            r_o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_error  <= w_err;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_err_clr) begin
            r_err_cnt <= '0;
        end else if (w_deliver && r_error && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ONE_C;
        end
    end

    assign o_ready   = w_ready;
    assign o_valid   = r_o_valid;
    assign o_result  = r_result;
    assign o_error   = r_error;
    assign o_err_cnt = r_err_cnt;

endmodule
